// File: rtl/apb_master_bridge.sv
// Command-FIFO fed APB master: queues read/write commands and runs one APB transfer at a time.
// Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS phase and flags an error response.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    push_c, pop_c;

    logic                    fifo_write [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_wdata [FIFO_DEPTH];

    logic                    psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic                    rsp_valid_d, rsp_write_d, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    assign push_c = cmd_valid && cmd_ready;

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge PCLK) begin
        if (push_c) begin
            fifo_write[wr_ptr_q] <= cmd_write;
            fifo_addr[wr_ptr_q]  <= cmd_addr;
            fifo_wdata[wr_ptr_q] <= cmd_wdata;
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (count_q != '0) begin
                    pop_c     = 1'b1;
                    psel_d    = 1'b1;
                    pwrite_d  = fifo_write[rd_ptr_q];
                    paddr_d   = fifo_addr[rd_ptr_q];
                    pwdata_d  = fifo_write[rd_ptr_q] ? fifo_wdata[rd_ptr_q] : '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    rsp_write_d = PWRITE;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_write_d = PWRITE;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // All state and outputs; cmd_ready is precomputed from the next count.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_d;
            cmd_ready <= (count_d != CNT_W'(FIFO_DEPTH));
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB slave memory model.
// Build with or without APB_MASTER_TIMEOUT_EN; the stuck-slave step adapts.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] smem [16];
    logic        exp_w [5];
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    logic [31:0] exp_r [5];

    apb_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave memory: writes land on a completed ACCESS, reads are combinational.
    assign PRDATA = smem[PADDR[5:2]];
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR[5:2]] <= PWDATA;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        chk("push_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'(1));
    endtask

    initial begin
        int  n;
        logic seen;
        for (int i = 0; i < 16; i++) smem[i] = 32'h0;
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; rsp_ready = 1'b0; PREADY = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        PRESETn = 1'b1;
        tick();
        chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        // Write 0x10 <- DEADBEEF, slave ready on 2nd ACCESS cycle
        push(1'b1, 32'h10, 32'hDEAD_BEEF);
        chk("wr_idle_psel", 64'(PSEL), 64'(0));
        tick();
        chk("wr_setup_psel", 64'(PSEL), 64'(1));
        chk("wr_setup_penable", 64'(PENABLE), 64'(0));
        chk("wr_setup_pwrite", 64'(PWRITE), 64'(1));
        chk("wr_setup_paddr", 64'(PADDR), 64'(32'h10));
        chk("wr_setup_pwdata", 64'(PWDATA), 64'(32'hDEAD_BEEF));
        tick();
        chk("wr_acc1_penable", 64'(PENABLE), 64'(1));
        tick();
        chk("wr_acc2_psel", 64'(PSEL), 64'(1));
        chk("wr_acc2_penable", 64'(PENABLE), 64'(1));
        chk("wr_acc2_paddr", 64'(PADDR), 64'(32'h10));
        chk("wr_acc2_pwdata", 64'(PWDATA), 64'(32'hDEAD_BEEF));
        chk("wr_acc2_rsp_valid", 64'(rsp_valid), 64'(0));
        PREADY = 1'b1;
        tick();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("wr_rsp_write", 64'(rsp_write), 64'(1));
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("wr_rsp_err", 64'(rsp_err), 64'(0));
        chk("wr_rsp_psel", 64'(PSEL), 64'(0));
        rsp_ready = 1'b1;
        tick();
        chk("wr_hs_rsp_valid", 64'(rsp_valid), 64'(0));

        // Read back 0x10 with immediate PREADY: minimum latency 3
        push(1'b0, 32'h10, 32'h5555_5555);
        wait_rsp(n);
        chk("rd_latency", 64'(n), 64'(3));
        chk("rd_rsp_write", 64'(rsp_write), 64'(0));
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
        chk("rd_pwdata_zero", 64'(PWDATA), 64'(0));
        tick();
        chk("rd_hs_rsp_valid", 64'(rsp_valid), 64'(0));

        // Five back-to-back commands against a stalled slave; pointers wrap
        exp_w[0] = 1'b1; exp_a[0] = 32'h20; exp_d[0] = 32'h1111_0000; exp_r[0] = 32'h0;
        exp_w[1] = 1'b0; exp_a[1] = 32'h20; exp_d[1] = 32'h0;         exp_r[1] = 32'h1111_0000;
        exp_w[2] = 1'b1; exp_a[2] = 32'h24; exp_d[2] = 32'h2222_0002; exp_r[2] = 32'h0;
        exp_w[3] = 1'b0; exp_a[3] = 32'h24; exp_d[3] = 32'h0;         exp_r[3] = 32'h2222_0002;
        exp_w[4] = 1'b0; exp_a[4] = 32'h10; exp_d[4] = 32'h0;         exp_r[4] = 32'hDEAD_BEEF;
        PREADY = 1'b0;
        for (int k = 0; k < 5; k++) push(exp_w[k], exp_a[k], exp_d[k]);
        chk("full_cmd_ready", 64'(cmd_ready), 64'(0));
        tick(); tick();
        chk("full_cmd_ready_hold", 64'(cmd_ready), 64'(0));
        chk("stall_penable", 64'(PENABLE), 64'(1));
        chk("stall_paddr", 64'(PADDR), 64'(32'h20));
        chk("stall_pwdata", 64'(PWDATA), 64'(32'h1111_0000));
        PREADY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(n);
            chk("burst_rsp_write", 64'(rsp_write), 64'(exp_w[k]));
            chk("burst_rsp_rdata", 64'(rsp_rdata), 64'(exp_r[k]));
            chk("burst_rsp_err", 64'(rsp_err), 64'(0));
            tick();
        end
        chk("burst_drained_ready", 64'(cmd_ready), 64'(1));
        chk("burst_drained_valid", 64'(rsp_valid), 64'(0));

        // Response back-pressure for 6 cycles with a second command queued
        rsp_ready = 1'b0;
        push(1'b0, 32'h24, 32'h0);
        push(1'b1, 32'h28, 32'h3333_3333);
        wait_rsp(n);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'h2222_0002));
            chk("bp_psel", 64'(PSEL), 64'(0));
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_hs_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("bp_hs_psel", 64'(PSEL), 64'(0));
        tick();
        chk("bp_next_psel", 64'(PSEL), 64'(1));
        chk("bp_next_paddr", 64'(PADDR), 64'(32'h28));
        wait_rsp(n);
        chk("bp_wr_rsp_write", 64'(rsp_write), 64'(1));
        chk("bp_wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
        tick();

        // Reset during ACCESS with two commands queued
        PREADY = 1'b0; rsp_ready = 1'b0;
        push(1'b1, 32'h30, 32'hAAAA_0001);
        push(1'b1, 32'h34, 32'hAAAA_0002);
        push(1'b1, 32'h38, 32'hAAAA_0003);
        chk("abort_in_access", 64'(PENABLE), 64'(1));
        PRESETn = 1'b0;
        tick();
        chk("abort_psel", 64'(PSEL), 64'(0));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_cmd_ready_rst", 64'(cmd_ready), 64'(0));
        PRESETn = 1'b1; PREADY = 1'b1; rsp_ready = 1'b1;
        tick();
        chk("abort_cmd_ready_rel", 64'(cmd_ready), 64'(1));
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | PSEL | rsp_valid;
        end
        chk("abort_no_activity", 64'(seen), 64'(0));
        chk("abort_slave_untouched", 64'(smem[12]), 64'(0));

        // Slave stuck: timeout build errors out, default build waits
        PREADY = 1'b0; rsp_ready = 1'b0;
        push(1'b0, 32'h10, 32'h0);
        tick(); tick();
        chk("stuck_penable", 64'(PENABLE), 64'(1));
`ifdef APB_MASTER_TIMEOUT_EN
        n = 0;
        while (PSEL && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'(16));
        chk("to_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("to_rsp_err", 64'(rsp_err), 64'(1));
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'(0));
        rsp_ready = 1'b1;
        tick();
        chk("to_hs_rsp_valid", 64'(rsp_valid), 64'(0));
`else
        for (int k = 0; k < 40; k++) tick();
        chk("hold_psel", 64'(PSEL), 64'(1));
        chk("hold_penable", 64'(PENABLE), 64'(1));
        chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));
        PREADY = 1'b1;
        wait_rsp(n);
        chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
        chk("hold_rsp_err", 64'(rsp_err), 64'(0));
        rsp_ready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
